// File: rtl/operand_stream_buffer.sv
// Operand store for the convolution datapath: loads matrix A and filter B, then streams KxK windows of A.
// Optional macro ZERO_PAD_EN selects "same" padding (P=(K-1)/2, K odd); default build streams valid-only windows.
module operand_stream_buffer #(
  parameter int DATA_W = 8,
  parameter int A_ROWS = 4,
  parameter int A_COLS = 4,
  parameter int K      = 3,
`ifdef ZERO_PAD_EN
  localparam int NR    = A_ROWS,
  localparam int NC    = A_COLS,
`else
  localparam int NR    = A_ROWS - K + 1,
  localparam int NC    = A_COLS - K + 1,
`endif
  localparam int ROW_W = $clog2(NR) + 1,
  localparam int COL_W = $clog2(NC) + 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           clear,
  input  logic                           wr_valid,
  output logic                           wr_ready,
  input  logic                           wr_sel,
  input  logic [DATA_W-1:0]              wr_data,
  output logic                           a_full,
  output logic                           b_full,
  output logic [A_ROWS*A_COLS*DATA_W-1:0] a_flat,
  output logic [K*K*DATA_W-1:0]          b_flat,
  input  logic                           start,
  output logic                           busy,
  output logic                           win_valid,
  input  logic                           win_ready,
  output logic [K*K*DATA_W-1:0]          win_flat,
  output logic [ROW_W-1:0]               win_row,
  output logic [COL_W-1:0]               win_col,
  output logic                           win_last,
  output logic                           done
);

  localparam int A_N     = A_ROWS * A_COLS;
  localparam int B_N     = K * K;
  localparam int A_IDX_W = (A_N > 1) ? $clog2(A_N) : 1;
  localparam int B_IDX_W = (B_N > 1) ? $clog2(B_N) : 1;
`ifdef ZERO_PAD_EN
  localparam int P       = (K - 1) / 2;
`endif

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_FULL   = 2'd1,
    ST_STREAM = 2'd2
  } state_t;

  state_t               state_r;
  state_t               state_nxt_s;

  logic [DATA_W-1:0]    a_mem_r [A_N];
  logic [DATA_W-1:0]    b_mem_r [B_N];
  logic [A_IDX_W-1:0]   a_ptr_r;
  logic [B_IDX_W-1:0]   b_ptr_r;
  logic                 a_full_r;
  logic                 b_full_r;
  logic [ROW_W-1:0]     row_r;
  logic [COL_W-1:0]     col_r;
  logic                 done_r;

  logic                 wr_ready_s;
  logic                 a_wr_s;
  logic                 b_wr_s;
  logic                 stream_s;
  logic                 hs_s;
  logic                 row_end_s;
  logic                 col_end_s;
  logic                 last_s;

  // A write in the same cycle as clear is dropped, so clear gates the write strobes.
  assign wr_ready_s = (state_r == ST_LOAD) & (wr_sel ? ~b_full_r : ~a_full_r);
  assign a_wr_s     = wr_valid & wr_ready_s & ~wr_sel & ~clear;
  assign b_wr_s     = wr_valid & wr_ready_s &  wr_sel & ~clear;
  assign stream_s   = (state_r == ST_STREAM);
  assign hs_s       = stream_s & win_ready;
  assign row_end_s  = (row_r == ROW_W'(NR - 1));
  assign col_end_s  = (col_r == COL_W'(NC - 1));
  assign last_s     = row_end_s & col_end_s;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_LOAD;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; clear overrides every other transition.
  always_comb begin
    state_nxt_s = state_r;
    if (clear) begin
      state_nxt_s = ST_LOAD;
    end else begin
      case (state_r)
        ST_LOAD: begin
          if (a_full_r & b_full_r) state_nxt_s = ST_FULL;
          else                     state_nxt_s = ST_LOAD;
        end
        ST_FULL: begin
          if (start) state_nxt_s = ST_STREAM;
          else       state_nxt_s = ST_FULL;
        end
        ST_STREAM: begin
          if (hs_s & last_s) state_nxt_s = ST_FULL;
          else               state_nxt_s = ST_STREAM;
        end
        default: state_nxt_s = ST_LOAD;
      endcase
    end
  end

  // Matrix A storage and write pointer; the pointer parks on the last slot once full.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int n = 0; n < A_N; n++) a_mem_r[n] <= {DATA_W{1'b0}};
      a_ptr_r  <= {A_IDX_W{1'b0}};
      a_full_r <= 1'b0;
    end else if (clear) begin
      for (int n = 0; n < A_N; n++) a_mem_r[n] <= {DATA_W{1'b0}};
      a_ptr_r  <= {A_IDX_W{1'b0}};
      a_full_r <= 1'b0;
    end else if (a_wr_s) begin
      a_mem_r[a_ptr_r] <= wr_data;
      if (a_ptr_r == A_IDX_W'(A_N - 1)) a_full_r <= 1'b1;
      else                              a_ptr_r  <= a_ptr_r + A_IDX_W'(1);
    end
  end

  // Filter B storage and write pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int n = 0; n < B_N; n++) b_mem_r[n] <= {DATA_W{1'b0}};
      b_ptr_r  <= {B_IDX_W{1'b0}};
      b_full_r <= 1'b0;
    end else if (clear) begin
      for (int n = 0; n < B_N; n++) b_mem_r[n] <= {DATA_W{1'b0}};
      b_ptr_r  <= {B_IDX_W{1'b0}};
      b_full_r <= 1'b0;
    end else if (b_wr_s) begin
      b_mem_r[b_ptr_r] <= wr_data;
      if (b_ptr_r == B_IDX_W'(B_N - 1)) b_full_r <= 1'b1;
      else                              b_ptr_r  <= b_ptr_r + B_IDX_W'(1);
    end
  end

  // Window position counters (row-major walk) and the end-of-stream pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_r  <= {ROW_W{1'b0}};
      col_r  <= {COL_W{1'b0}};
      done_r <= 1'b0;
    end else if (clear) begin
      row_r  <= {ROW_W{1'b0}};
      col_r  <= {COL_W{1'b0}};
      done_r <= 1'b0;
    end else begin
      done_r <= hs_s & last_s;
      if ((state_r == ST_FULL) && start) begin
        row_r <= {ROW_W{1'b0}};
        col_r <= {COL_W{1'b0}};
      end else if (hs_s) begin
        if (col_end_s) begin
          col_r <= {COL_W{1'b0}};
          row_r <= row_end_s ? {ROW_W{1'b0}} : (row_r + ROW_W'(1));
        end else begin
          col_r <= col_r + COL_W'(1);
        end
      end
    end
  end

  for (genvar ga = 0; ga < A_N; ga++) begin : g_a_flat
    assign a_flat[ga*DATA_W +: DATA_W] = a_mem_r[ga];
  end

  for (genvar gb = 0; gb < B_N; gb++) begin : g_b_flat
    assign b_flat[gb*DATA_W +: DATA_W] = b_mem_r[gb];
  end

  for (genvar gi = 0; gi < K; gi++) begin : g_win_r
    for (genvar gj = 0; gj < K; gj++) begin : g_win_c
      logic [DATA_W-1:0] elem_s;
`ifdef ZERO_PAD_EN
      int src_r_s;
      int src_c_s;
      // Padded tap: positions outside A read as zero.
      always_comb begin
        src_r_s = int'(row_r) + gi - P;
        src_c_s = int'(col_r) + gj - P;
        if ((src_r_s >= 0) && (src_r_s < A_ROWS) && (src_c_s >= 0) && (src_c_s < A_COLS)) begin
          elem_s = a_mem_r[A_IDX_W'(src_r_s * A_COLS + src_c_s)];
        end else begin
          elem_s = {DATA_W{1'b0}};
        end
      end
`else
      // Valid-only tap: always inside A by construction of the window grid.
      always_comb begin
        elem_s = a_mem_r[A_IDX_W'((int'(row_r) + gi) * A_COLS + int'(col_r) + gj)];
      end
`endif
      assign win_flat[(gi*K + gj)*DATA_W +: DATA_W] = elem_s;
    end
  end

  assign wr_ready  = wr_ready_s;
  assign a_full    = a_full_r;
  assign b_full    = b_full_r;
  assign busy      = stream_s;
  assign win_valid = stream_s;
  assign win_row   = row_r;
  assign win_col   = col_r;
  assign win_last  = stream_s & last_s;
  assign done      = done_r;

endmodule

// File: tb/tb_operand_stream_buffer.sv
// Self-checking bench for operand_stream_buffer: table-driven load, hand-written corner sequences,
// and randomized load/stream compared against a window model built from plain array arithmetic.
module tb_operand_stream_buffer;

  localparam int DATA_W = 8;
  localparam int A_ROWS = 4;
  localparam int A_COLS = 4;
  localparam int K      = 3;
  localparam int A_N    = A_ROWS * A_COLS;
  localparam int B_N    = K * K;
`ifdef ZERO_PAD_EN
  localparam int PM  = (K - 1) / 2;
  localparam int NRM = A_ROWS;
  localparam int NCM = A_COLS;
`else
  localparam int PM  = 0;
  localparam int NRM = A_ROWS - K + 1;
  localparam int NCM = A_COLS - K + 1;
`endif
  localparam int ROW_W = $clog2(NRM) + 1;
  localparam int COL_W = $clog2(NCM) + 1;

  logic                       clk = 1'b0;
  logic                       rst = 1'b1;
  logic                       clear = 1'b0;
  logic                       wr_valid = 1'b0;
  logic                       wr_ready;
  logic                       wr_sel = 1'b0;
  logic [DATA_W-1:0]          wr_data = 8'h00;
  logic                       a_full;
  logic                       b_full;
  logic [A_N*DATA_W-1:0]      a_flat;
  logic [B_N*DATA_W-1:0]      b_flat;
  logic                       start = 1'b0;
  logic                       busy;
  logic                       win_valid;
  logic                       win_ready = 1'b0;
  logic [B_N*DATA_W-1:0]      win_flat;
  logic [ROW_W-1:0]           win_row;
  logic [COL_W-1:0]           win_col;
  logic                       win_last;
  logic                       done;

  operand_stream_buffer #(.DATA_W(DATA_W), .A_ROWS(A_ROWS), .A_COLS(A_COLS), .K(K)) dut (
    .clk(clk), .rst(rst), .clear(clear),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_sel(wr_sel), .wr_data(wr_data),
    .a_full(a_full), .b_full(b_full), .a_flat(a_flat), .b_flat(b_flat),
    .start(start), .busy(busy), .win_valid(win_valid), .win_ready(win_ready),
    .win_flat(win_flat), .win_row(win_row), .win_col(win_col), .win_last(win_last),
    .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference store: plain arrays plus fill counts.
  logic [7:0] a_m [A_N];
  logic [7:0] b_m [B_N];
  int a_cnt;
  int b_cnt;

  typedef int nine_t [9];

  typedef struct {
    logic       sel;
    logic [7:0] data;
    logic       exp_ready;
    logic       exp_a_full;
    logic       exp_b_full;
    logic       try_start;
  } wr_vec_t;

  wr_vec_t vecs [26];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int k = 0; k < A_N; k++) a_m[k] = 8'h00;
    for (int k = 0; k < B_N; k++) b_m[k] = 8'h00;
    a_cnt = 0;
    b_cnt = 0;
  endtask

  function automatic logic [127:0] a_pack();
    logic [127:0] v;
    v = '0;
    for (int k = 0; k < A_N; k++) v[k*8 +: 8] = a_m[k];
    return v;
  endfunction

  function automatic logic [127:0] b_pack();
    logic [127:0] v;
    v = '0;
    for (int k = 0; k < B_N; k++) v[k*8 +: 8] = b_m[k];
    return v;
  endfunction

  // Window (r,c): element (i,j) = A[r+i-PM][c+j-PM], zero when outside A.
  function automatic logic [127:0] win_model(input int r, input int c);
    logic [127:0] v;
    int ar;
    int ac;
    v = '0;
    for (int i = 0; i < K; i++) begin
      for (int j = 0; j < K; j++) begin
        ar = r + i - PM;
        ac = c + j - PM;
        if (ar >= 0 && ar < A_ROWS && ac >= 0 && ac < A_COLS)
          v[(i*K + j)*8 +: 8] = a_m[ar*A_COLS + ac];
      end
    end
    return v;
  endfunction

  function automatic logic [127:0] pack9(input nine_t e);
    logic [127:0] v;
    v = '0;
    for (int k = 0; k < 9; k++) v[k*8 +: 8] = 8'(e[k]);
    return v;
  endfunction

  task automatic do_write(input logic sel, input logic [7:0] d, output logic acc);
    logic exp_rdy;
    exp_rdy = sel ? (b_cnt < B_N) : (a_cnt < A_N);
    wr_valid = 1'b1;
    wr_sel   = sel;
    wr_data  = d;
    @(negedge clk);
    acc = wr_ready;
    chk("wr_ready", wr_ready, exp_rdy);
    tick();
    wr_valid = 1'b0;
    if (exp_rdy) begin
      if (sel) begin b_m[b_cnt] = d; b_cnt++; end
      else     begin a_m[a_cnt] = d; a_cnt++; end
    end
    chk("a_flat", a_flat, a_pack());
    chk("b_flat", b_flat, b_pack());
    chk("a_full", a_full, a_cnt == A_N);
    chk("b_full", b_full, b_cnt == B_N);
  endtask

  task automatic run_stream(input int pct, output logic [127:0] first_w, output logic [127:0] last_w);
    logic rdy;
    int   guard;
    first_w = '0;
    last_w  = '0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int r = 0; r < NRM; r++) begin
      for (int c = 0; c < NCM; c++) begin
        guard = 0;
        do begin
          rdy = ($urandom_range(99) < pct) || (guard >= 40);
          win_ready = rdy;
          @(negedge clk);
          chk("win_valid", win_valid, 1'b1);
          chk("win_row", win_row, r);
          chk("win_col", win_col, c);
          chk("win_flat", win_flat, win_model(r, c));
          chk("win_last", win_last, (r == NRM-1) && (c == NCM-1));
          chk("done_idle", done, 1'b0);
          if (r == 0 && c == 0) first_w = win_flat;
          if (r == NRM-1 && c == NCM-1) last_w = win_flat;
          tick();
          guard++;
        end while (!rdy);
      end
    end
    win_ready = 1'b0;
    @(negedge clk);
    chk("end_valid", win_valid, 1'b0);
    chk("end_busy", busy, 1'b0);
    chk("done_pulse", done, 1'b1);
    tick();
    @(negedge clk);
    chk("done_once", done, 1'b0);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic acc;
    logic [127:0] fw;
    logic [127:0] lw;
    int n;
    int nr;
    int nc;
    int guard;

    // Load table: A and B interleaved, an overfill B write, then the rest of A.
    n = 0;
    for (int i = 0; i < 9; i++) begin
      vecs[n] = '{1'b0, 8'(i+1), 1'b1, 1'b0, 1'b0, 1'b0}; n++;
      vecs[n] = '{1'b1, 8'(i+1), 1'b1, 1'b0, (i == 8), 1'b0}; n++;
    end
    vecs[n] = '{1'b1, 8'hEE, 1'b0, 1'b0, 1'b1, 1'b1}; n++;
    for (int i = 9; i < 16; i++) begin
      vecs[n] = '{1'b0, 8'(i+1), 1'b1, (i == 15), 1'b1, 1'b0}; n++;
    end

    model_clear();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_wr_ready", wr_ready, 1'b1);
    chk("rst_a_full", a_full, 1'b0);
    chk("rst_b_full", b_full, 1'b0);
    chk("rst_a_flat", a_flat, '0);
    chk("rst_b_flat", b_flat, '0);
    chk("rst_win_valid", win_valid, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_row", win_row, 0);
    chk("rst_col", win_col, 0);
    chk("rst_win_flat", win_flat, '0);

    // Asynchronous reset in the middle of loading A.
    for (int i = 0; i < 5; i++) do_write(1'b0, 8'(i+1), acc);
    #2 rst = 1'b1;
    #1;
    wr_sel = 1'b0;
    #1;
    chk("mid_rst_a_full", a_full, 1'b0);
    chk("mid_rst_a_flat", a_flat, '0);
    chk("mid_rst_wr_ready", wr_ready, 1'b1);
    chk("mid_rst_win_valid", win_valid, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    model_clear();

    for (int v = 0; v < 26; v++) begin
      do_write(vecs[v].sel, vecs[v].data, acc);
      chk("vec_ready", acc, vecs[v].exp_ready);
      chk("vec_a_full", a_full, vecs[v].exp_a_full);
      chk("vec_b_full", b_full, vecs[v].exp_b_full);
      if (vecs[v].try_start) begin
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("early_start_busy", busy, 1'b0);
        chk("early_start_valid", win_valid, 1'b0);
      end
    end
    wr_sel = 1'b0;
    tick();
    tick();

    run_stream(100, fw, lw);
`ifdef ZERO_PAD_EN
    chk("first_window", fw, pack9('{0,0,0,0,1,2,0,5,6}));
    chk("last_window", lw, pack9('{11,12,0,15,16,0,0,0,0}));
`else
    chk("first_window", fw, pack9('{1,2,3,5,6,7,9,10,11}));
    chk("last_window", lw, pack9('{6,7,8,10,11,12,14,15,16}));
`endif

    // Backpressure on window (0,1), replaying the retained operands.
    start = 1'b1;
    tick();
    start = 1'b0;
    win_ready = 1'b1;
    @(negedge clk);
    chk("bp_first_col", win_col, 0);
    tick();
    win_ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      chk("bp_hold_valid", win_valid, 1'b1);
      chk("bp_hold_row", win_row, 0);
      chk("bp_hold_col", win_col, 1);
      chk("bp_hold_flat", win_flat, win_model(0, 1));
      tick();
    end
    win_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_col", win_col, 1);
    tick();
    nr = 0;
    nc = 2;
    if (nc >= NCM) begin nc = 0; nr = 1; end
    @(negedge clk);
    chk("bp_next_row", win_row, nr);
    chk("bp_next_col", win_col, nc);
    chk("bp_next_flat", win_flat, win_model(nr, nc));
    guard = 0;
    while (!done && guard < 64) begin
      tick();
      @(negedge clk);
      guard++;
    end
    chk("bp_done", done, 1'b1);
    chk("bp_done_valid", win_valid, 1'b0);
    win_ready = 1'b0;
    tick();

    // Clear while the second window is presented (and accepted) aborts the stream.
    start = 1'b1;
    tick();
    start = 1'b0;
    win_ready = 1'b1;
    @(negedge clk);
    tick();
    clear = 1'b1;
    @(negedge clk);
    chk("clr_pre_col", win_col, 1);
    tick();
    clear = 1'b0;
    win_ready = 1'b0;
    model_clear();
    chk("clr_valid", win_valid, 1'b0);
    chk("clr_busy", busy, 1'b0);
    chk("clr_done", done, 1'b0);
    chk("clr_a_flat", a_flat, '0);
    chk("clr_b_flat", b_flat, '0);
    chk("clr_a_full", a_full, 1'b0);
    chk("clr_wr_ready", wr_ready, 1'b1);
    chk("clr_row", win_row, 0);
    chk("clr_col", win_col, 0);
    @(negedge clk);
    chk("clr_no_done", done, 1'b0);
    tick();

    // Randomized reload and stream against the model; one iteration replays without reload.
    for (int it = 0; it < 3; it++) begin
      guard = 0;
      while ((a_cnt < A_N || b_cnt < B_N) && guard < 300) begin
        do_write(1'($urandom_range(1)), 8'($urandom_range(255)), acc);
        if ($urandom_range(3) == 0) tick();
        guard++;
      end
      chk("rand_loaded", (a_cnt == A_N) && (b_cnt == B_N), 1'b1);
      wr_sel = 1'b0;
      tick();
      tick();
      run_stream(30 + $urandom_range(70), fw, lw);
      if (it == 1) run_stream(50, fw, lw);
      clear = 1'b1;
      tick();
      clear = 1'b0;
      model_clear();
      chk("rand_clr_a_flat", a_flat, '0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/operand_stream_buffer.md
Name: operand_stream_buffer

Overview:
Parametrised operand store for the convolution datapath, replacing fixed per-element operand registers. Loads an input matrix A (A_ROWS x A_COLS) and a square filter B (K x K) through a valid/ready write port. Exposes both as flattened buses. On command, streams every KxK convolution window of A to the systolic array over a valid/ready handshake.

Parameters:
DATA_W, 8, element width in bits
A_ROWS, 4, rows of matrix A
A_COLS, 4, columns of matrix A
K, 3, filter size; K <= A_ROWS and K <= A_COLS

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
clear  in  1  synchronous clear: zero storage, pointers and flags; state -> LOAD
wr_valid  in  1  write element valid
wr_ready  out  1  = (state==LOAD) & !full[wr_sel]
wr_sel  in  1  0 = matrix A, 1 = filter B
wr_data  in  DATA_W  element in raster order (row-major)
a_full  out  1  all A_ROWS*A_COLS elements of A written
b_full  out  1  all K*K elements of B written
a_flat  out  A_ROWS*A_COLS*DATA_W  A[r][c] at bits [(r*A_COLS+c)*DATA_W +: DATA_W]
b_flat  out  K*K*DATA_W  B[i][j] at bits [(i*K+j)*DATA_W +: DATA_W]
start  in  1  begin window streaming; honoured only in state FULL
busy  out  1  state==STREAM
win_valid  out  1  window valid
win_ready  in  1  consumer accepts window
win_flat  out  K*K*DATA_W  window element (i,j) = A[row+i][col+j] at index i*K+j
win_row  out  $clog2(NR)+1  current window row
win_col  out  $clog2(NC)+1  current window column
win_last  out  1  final window, qualified by win_valid
done  out  1  one-cycle pulse after final window handshake

Behaviour:
- Reset (async) and clear (sync): all A/B storage 0, both write pointers 0, a_full=b_full=0, state LOAD. win_valid, done, win_row, win_col all 0. win_flat follows storage, so 0.
- Priority in a cycle: rst > clear > write/start/handshake. A write presented with clear is discarded.
- LOAD: a write is accepted when wr_valid & wr_ready. It stores into the selected matrix at that matrix's pointer; pointer increments. The write of the final element sets that matrix's full flag; the pointer does not wrap. Writes to a full matrix stall (wr_ready=0). A and B writes may interleave freely. When a_full & b_full, go to FULL next cycle.
- FULL: wr_ready=0. start=1 -> STREAM. win_valid=1 from the next cycle with window (0,0). start in LOAD or STREAM is ignored.
- STREAM: win_row, win_col and win_flat are stable while win_valid & !win_ready.
- Window order: on each handshake, advance row-major. col increments to NC-1, then wraps to 0 with row+1.
- Window grid: NR = A_ROWS-K+1, NC = A_COLS-K+1; defaults give 2x2 = 4 windows.
- win_last = (row==NR-1) & (col==NC-1).
- On the handshake of the last window: win_valid=0 and done=1 next cycle, state -> FULL. Operands are retained, so start may replay the stream.
- clear during STREAM aborts the stream: win_valid=0 next cycle, no done pulse.
- win_flat is combinational from storage and the window counters. No extra latency beyond the registered row/col.
- a_flat and b_flat are always the current storage contents, including partially loaded matrices.
- Storage is not writable outside LOAD; contents change only via write, clear or rst.

Optional Feature:
Macro ZERO_PAD_EN.
- Defined: "same" padding with P=(K-1)/2; K must be odd.
  - NR=A_ROWS, NC=A_COLS.
  - Window element (i,j) = A[row+i-P][col+j-P], or 0 if the index is outside A.
  - Defaults give 16 windows.
- Undefined: valid-only windows as above; no padding logic is synthesised.

Test Plan:
1. Reset check: assert rst mid-load after 5 A writes -> a_full=0, a_flat=0, wr_ready=1 for sel 0, win_valid=0.
2. Load and stream: write A=1..16 and B=1..9 interleaved, then start with win_ready=1.
   - Exactly 4 windows follow.
   - First window = {1,2,3,5,6,7,9,10,11}.
   - Last window = {6,7,8,10,11,12,14,15,16} with win_last=1.
   - done pulses once.
3. Backpressure: hold win_ready=0 for 3 cycles on window (0,1) -> win_flat={2,3,4,6,7,8}… and win_row=0, win_col=1 are unchanged; the handshake then advances to (1,0).
4. Overfill: after 9 B writes -> b_full=1 and wr_ready=0 for sel=1; a 10th B write stalls and leaves b_flat unchanged. start while A is not full is ignored.
5. Clear mid-stream: clear on the 2nd window -> win_valid=0 next cycle, no done, state LOAD, a_flat=0. A subsequent reload and stream works.
6. With ZERO_PAD_EN defined, A=1..16 -> 16 windows.
   - First window = {0,0,0,0,1,2,0,5,6}.
   - Last window = {11,12,0,15,16,0,0,0,0}.
